// File: rtl/dma_fifo_pkg.sv
// Shared types and width helpers for the multi-channel DMA FIFO.
// DMA_FIFO_ERR_EN enables sticky overflow/underflow flags.
package dma_fifo_pkg;

    localparam int FIFO_AW_MAX = 12;
    localparam int FIFO_LW_MAX = FIFO_AW_MAX + 1;

    typedef struct packed {
        logic [FIFO_AW_MAX-1:0] wr_ptr;
        logic [FIFO_AW_MAX-1:0] rd_ptr;
        logic [FIFO_LW_MAX-1:0] level;
    } dma_fifo_ch_state_t;

    function automatic int fifo_ch_w(input int ch_num);
        return (ch_num <= 1) ? 1 : $clog2(ch_num);
    endfunction

    function automatic int fifo_lvl_w(input int aw);
        return aw + 1;
    endfunction

endpackage

// File: rtl/dma_fifo_ch_ctrl.sv
// One channel's pointers, fill level and flags for dma_mc_sync_fifo.
// DMA_FIFO_ERR_EN adds sticky overflow/underflow bits.
module dma_fifo_ch_ctrl
    import dma_fifo_pkg::*;
#(
    parameter int AW         = 4,
    parameter int AFULL_THR  = (1 << AW) - 2,
    parameter int AEMPTY_THR = 2
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          enable,
    input  logic          i_flush,
    input  logic          i_wr_req,
    input  logic          i_rd_req,
    output logic          o_wr_acc,
    output logic          o_rd_acc,
    output logic [AW-1:0] o_wr_ptr,
    output logic [AW-1:0] o_rd_ptr,
    output logic          o_full,
    output logic          o_empty,
    output logic          o_afull,
    output logic          o_aempty,
`ifdef DMA_FIFO_ERR_EN
    output logic          o_ovf,
    output logic          o_udf,
`endif
    output logic [AW:0]   o_level
);

    localparam int DEPTH = 1 << AW;
    localparam logic [FIFO_AW_MAX-1:0] PTR_MASK  = FIFO_AW_MAX'(DEPTH - 1);
    localparam logic [FIFO_LW_MAX-1:0] LVL_FULL  = FIFO_LW_MAX'(DEPTH);
    localparam logic [FIFO_LW_MAX-1:0] LVL_AFULL = FIFO_LW_MAX'(AFULL_THR);
    localparam logic [FIFO_LW_MAX-1:0] LVL_AEMPT = FIFO_LW_MAX'(AEMPTY_THR);

    dma_fifo_ch_state_t st_q, st_d;

    logic full;
    logic empty;
    logic flush_en;
    logic wr_acc;
    logic rd_acc;

    assign full     = (st_q.level == LVL_FULL);
    assign empty    = (st_q.level == '0);
    assign flush_en = enable & i_flush;
    assign wr_acc   = enable & i_wr_req & ~full & ~i_flush;
    assign rd_acc   = enable & i_rd_req & ~empty & ~i_flush;

    always_comb begin
        st_d = st_q;
        if (flush_en) begin
            st_d = '0;
        end else begin
            if (wr_acc) st_d.wr_ptr = (st_q.wr_ptr + 1'b1) & PTR_MASK;
            if (rd_acc) st_d.rd_ptr = (st_q.rd_ptr + 1'b1) & PTR_MASK;
            unique case ({wr_acc, rd_acc})
                2'b10:   st_d.level = st_q.level + 1'b1;
                2'b01:   st_d.level = st_q.level - 1'b1;
                default: st_d.level = st_q.level;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) st_q <= '0;
        else         st_q <= st_d;
    end

    assign o_wr_acc = wr_acc;
    assign o_rd_acc = rd_acc;
    assign o_wr_ptr = st_q.wr_ptr[AW-1:0];
    assign o_rd_ptr = st_q.rd_ptr[AW-1:0];
    assign o_level  = st_q.level[AW:0];
    assign o_full   = full;
    assign o_empty  = empty;
    assign o_afull  = (st_q.level >= LVL_AFULL);
    assign o_aempty = (st_q.level <= LVL_AEMPT);

`ifdef DMA_FIFO_ERR_EN
    logic ovf_q, ovf_d;
    logic udf_q, udf_d;

    // Flush clears even when a set condition occurs in the same cycle.
    always_comb begin
        ovf_d = ovf_q | (enable & i_wr_req & full);
        udf_d = udf_q | (enable & i_rd_req & empty);
        if (flush_en) begin
            ovf_d = 1'b0;
            udf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    assign o_ovf = ovf_q;
    assign o_udf = udf_q;
`endif

endmodule

// File: rtl/dma_mc_sync_fifo.sv
// Multi-channel synchronous FIFO sharing one RAM, region {ch, ptr} per channel.
// DMA_FIFO_ERR_EN adds sticky o_ovf/o_udf per channel.
module dma_mc_sync_fifo
    import dma_fifo_pkg::*;
#(
    parameter int FIFO_ADDR_WIDTH  = 4,
    parameter int FIFO_DATA_WIDTH  = 64,
    parameter int FIFO_CH_NUM      = 4,
    parameter int AFULL_THR        = (1 << FIFO_ADDR_WIDTH) - 2,
    parameter int AEMPTY_THR       = 2,
    localparam int CW              = fifo_ch_w(FIFO_CH_NUM),
    localparam int LW              = fifo_lvl_w(FIFO_ADDR_WIDTH)
) (
    input  logic                       clk,
    input  logic                       nreset,
    input  logic                       enable,
    input  logic [FIFO_CH_NUM-1:0]     i_flush,
    input  logic                       i_wr_valid,
    input  logic [CW-1:0]              i_wr_ch,
    input  logic [FIFO_DATA_WIDTH-1:0] i_wr_data,
    input  logic                       i_rd_valid,
    input  logic [CW-1:0]              i_rd_ch,
    output logic [FIFO_DATA_WIDTH-1:0] o_rd_data,
    output logic                       o_rd_data_valid,
    output logic [FIFO_CH_NUM-1:0]     o_full,
    output logic [FIFO_CH_NUM-1:0]     o_empty,
    output logic [FIFO_CH_NUM-1:0]     o_afull,
    output logic [FIFO_CH_NUM-1:0]     o_aempty,
`ifdef DMA_FIFO_ERR_EN
    output logic [FIFO_CH_NUM-1:0]     o_ovf,
    output logic [FIFO_CH_NUM-1:0]     o_udf,
`endif
    output logic [FIFO_CH_NUM*LW-1:0]  o_level
);

    localparam int AW        = FIFO_ADDR_WIDTH;
    localparam int DEPTH     = 1 << AW;
    localparam int RAM_AW    = CW + AW;
    localparam int RAM_DEPTH = FIFO_CH_NUM * DEPTH;

    logic [FIFO_CH_NUM-1:0] wr_req;
    logic [FIFO_CH_NUM-1:0] rd_req;
    logic [FIFO_CH_NUM-1:0] wr_acc;
    logic [FIFO_CH_NUM-1:0] rd_acc;
    logic [AW-1:0]          wr_ptr [FIFO_CH_NUM];
    logic [AW-1:0]          rd_ptr [FIFO_CH_NUM];

    for (genvar c = 0; c < FIFO_CH_NUM; c++) begin : g_ch
        assign wr_req[c] = i_wr_valid & (i_wr_ch == CW'(c));
        assign rd_req[c] = i_rd_valid & (i_rd_ch == CW'(c));

        dma_fifo_ch_ctrl #(
            .AW         (AW),
            .AFULL_THR  (AFULL_THR),
            .AEMPTY_THR (AEMPTY_THR)
        ) u_ch (
            .clk      (clk),
            .nreset   (nreset),
            .enable   (enable),
            .i_flush  (i_flush[c]),
            .i_wr_req (wr_req[c]),
            .i_rd_req (rd_req[c]),
            .o_wr_acc (wr_acc[c]),
            .o_rd_acc (rd_acc[c]),
            .o_wr_ptr (wr_ptr[c]),
            .o_rd_ptr (rd_ptr[c]),
            .o_full   (o_full[c]),
            .o_empty  (o_empty[c]),
            .o_afull  (o_afull[c]),
            .o_aempty (o_aempty[c]),
`ifdef DMA_FIFO_ERR_EN
            .o_ovf    (o_ovf[c]),
            .o_udf    (o_udf[c]),
`endif
            .o_level  (o_level[c*LW +: LW])
        );
    end

    logic                       ram_we;
    logic                       ram_re;
    logic [RAM_AW-1:0]          ram_waddr;
    logic [RAM_AW-1:0]          ram_raddr;
    logic [FIFO_DATA_WIDTH-1:0] ram [RAM_DEPTH];

    // At most one channel accepts per side, so the OR-select is one-hot.
    always_comb begin
        ram_we    = 1'b0;
        ram_re    = 1'b0;
        ram_waddr = '0;
        ram_raddr = '0;
        for (int c = 0; c < FIFO_CH_NUM; c++) begin
            if (wr_acc[c]) begin
                ram_we    = 1'b1;
                ram_waddr = {CW'(c), wr_ptr[c]};
            end
            if (rd_acc[c]) begin
                ram_re    = 1'b1;
                ram_raddr = {CW'(c), rd_ptr[c]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we) ram[ram_waddr] <= i_wr_data;
    end

    logic [FIFO_DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                       rd_valid_q, rd_valid_d;

    always_comb begin
        rd_data_d  = rd_data_q;
        rd_valid_d = ram_re;
        if (ram_re) rd_data_d = ram[ram_raddr];
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign o_rd_data       = rd_data_q;
    assign o_rd_data_valid = rd_valid_q;

endmodule

// File: tb/tb_dma_mc_sync_fifo.sv
// Directed vector bench for dma_mc_sync_fifo (DEPTH=16, 4 channels).
// With DMA_FIFO_ERR_EN defined the sticky error flags are checked as well.
module tb_dma_mc_sync_fifo;

    logic        clk = 1'b0;
    logic        nreset;
    logic        enable;
    logic [3:0]  i_flush;
    logic        i_wr_valid;
    logic [1:0]  i_wr_ch;
    logic [63:0] i_wr_data;
    logic        i_rd_valid;
    logic [1:0]  i_rd_ch;
    logic [63:0] o_rd_data;
    logic        o_rd_data_valid;
    logic [3:0]  o_full, o_empty, o_afull, o_aempty;
    logic [19:0] o_level;
`ifdef DMA_FIFO_ERR_EN
    logic [3:0]  o_ovf, o_udf;
`endif

    always #5 clk = ~clk;

    dma_mc_sync_fifo dut (
        .clk             (clk),
        .nreset          (nreset),
        .enable          (enable),
        .i_flush         (i_flush),
        .i_wr_valid      (i_wr_valid),
        .i_wr_ch         (i_wr_ch),
        .i_wr_data       (i_wr_data),
        .i_rd_valid      (i_rd_valid),
        .i_rd_ch         (i_rd_ch),
        .o_rd_data       (o_rd_data),
        .o_rd_data_valid (o_rd_data_valid),
        .o_full          (o_full),
        .o_empty         (o_empty),
        .o_afull         (o_afull),
        .o_aempty        (o_aempty),
`ifdef DMA_FIFO_ERR_EN
        .o_ovf           (o_ovf),
        .o_udf           (o_udf),
`endif
        .o_level         (o_level)
    );

    typedef struct {
        logic        en;
        logic [3:0]  fl;
        logic        wv;
        logic [1:0]  wc;
        logic [63:0] wd;
        logic        rv;
        logic [1:0]  rc;
        logic        ev;
        logic [63:0] ed;
        int          l0, l1, l2, l3;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic void add(input logic en, input logic [3:0] fl,
                                input logic wv, input logic [1:0] wc,
                                input logic [63:0] wd,
                                input logic rv, input logic [1:0] rc,
                                input logic ev, input logic [63:0] ed,
                                input int l0, input int l1,
                                input int l2, input int l3);
        vec_t v;
        v.en = en; v.fl = fl; v.wv = wv; v.wc = wc; v.wd = wd;
        v.rv = rv; v.rc = rc; v.ev = ev; v.ed = ed;
        v.l0 = l0; v.l1 = l1; v.l2 = l2; v.l3 = l3;
        vecs.push_back(v);
    endfunction

    task automatic drive(input vec_t v);
        enable     = v.en;
        i_flush    = v.fl;
        i_wr_valid = v.wv;
        i_wr_ch    = v.wc;
        i_wr_data  = v.wd;
        i_rd_valid = v.rv;
        i_rd_ch    = v.rc;
    endtask

    task automatic check(input string tag, input int idx,
                         input logic ev, input logic [63:0] ed,
                         input int l0, input int l1,
                         input int l2, input int l3);
        int          lv [4];
        logic [19:0] el;
        logic [3:0]  ef, ee, eaf, eae;
        lv[0] = l0; lv[1] = l1; lv[2] = l2; lv[3] = l3;
        for (int c = 0; c < 4; c++) begin
            el[c*5 +: 5] = 5'(lv[c]);
            ef[c]  = (lv[c] == 16);
            ee[c]  = (lv[c] == 0);
            eaf[c] = (lv[c] >= 14);
            eae[c] = (lv[c] <= 2);
        end
        n_vec++;
        if (o_level !== el || o_full !== ef || o_empty !== ee ||
            o_afull !== eaf || o_aempty !== eae ||
            o_rd_data_valid !== ev || o_rd_data !== ed) begin
            n_bad++;
            $display("FAIL %s[%0d]: got lvl=%h f=%b e=%b af=%b ae=%b v=%b d=%h, want lvl=%h f=%b e=%b af=%b ae=%b v=%b d=%h",
                     tag, idx, o_level, o_full, o_empty, o_afull, o_aempty,
                     o_rd_data_valid, o_rd_data, el, ef, ee, eaf, eae, ev, ed);
        end
    endtask

    task automatic run_table(input string tag);
        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i]);
            @(posedge clk);
            #1;
            check(tag, i, vecs[i].ev, vecs[i].ed,
                  vecs[i].l0, vecs[i].l1, vecs[i].l2, vecs[i].l3);
        end
        vecs.delete();
    endtask

`ifdef DMA_FIFO_ERR_EN
    task automatic check_err(input string tag, input logic [3:0] eo,
                             input logic [3:0] eu);
        n_vec++;
        if (o_ovf !== eo || o_udf !== eu) begin
            n_bad++;
            $display("FAIL %s: got ovf=%b udf=%b, want ovf=%b udf=%b",
                     tag, o_ovf, o_udf, eo, eu);
        end
    endtask
`endif

    initial begin
        vec_t idle;
        idle = '{en: 1'b1, fl: 4'h0, wv: 1'b0, wc: 2'd0, wd: 64'h0,
                 rv: 1'b0, rc: 2'd0, ev: 1'b0, ed: 64'h0,
                 l0: 0, l1: 0, l2: 0, l3: 0};
        nreset = 1'b0;
        drive(idle);
        #12;
        check("reset", 0, 1'b0, 64'h0, 0, 0, 0, 0);
`ifdef DMA_FIFO_ERR_EN
        check_err("reset_err", 4'h0, 4'h0);
`endif
        @(negedge clk);
        nreset = 1'b1;

        // Fill ch1 past full, then drain it.
        for (int i = 0; i < 17; i++)
            add(1, 0, 1, 1, 64'h100 + i, 0, 0, 0, 0, 0, (i < 16) ? i + 1 : 16, 0, 0);
        for (int j = 0; j < 16; j++)
            add(1, 0, 0, 0, 0, 1, 1, 1, 64'h100 + j, 0, 15 - j, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0, 0, 64'h10F, 0, 0, 0, 0);
        run_table("t1_fill_drain");

        // Ch2 steady wr+rd with pointer wrap.
        for (int i = 0; i < 3; i++)
            add(1, 0, 1, 2, 64'h200 + i, 0, 0, 0, 64'h10F, 0, 0, i + 1, 0);
        for (int k = 0; k < 20; k++)
            add(1, 0, 1, 2, 64'h203 + k, 1, 2, 1, 64'h200 + k, 0, 0, 3, 0);
        for (int j = 0; j < 3; j++)
            add(1, 0, 0, 0, 0, 1, 2, 1, 64'h214 + j, 0, 0, 2 - j, 0);
        run_table("t2_wrap");

        // Interleaved ch0/ch3 streams, cross-channel wr+rd.
        for (int i = 0; i < 4; i++) begin
            add(1, 0, 1, 0, 64'hA00 + i, 0, 0, 0, 64'h216, i + 1, 0, 0, i);
            add(1, 0, 1, 3, 64'hB00 + i, 0, 0, 0, 64'h216, i + 1, 0, 0, i + 1);
        end
        for (int j = 0; j < 4; j++)
            add(1, 0, 0, 0, 0, 1, 3, 1, 64'hB00 + j, 4, 0, 0, 3 - j);
        for (int j = 0; j < 4; j++)
            add(1, 0, 1, 1, 64'hC00 + j, 1, 0, 1, 64'hA00 + j, 3 - j, j + 1, 0, 0);
        run_table("t3_interleave");

        // Flush ch0 against same-cycle wr+rd; ch1 untouched.
        for (int i = 0; i < 5; i++)
            add(1, 0, 1, 0, 64'hD00 + i, 0, 0, 0, 64'hA03, i + 1, 4, 0, 0);
        add(1, 4'b0001, 1, 0, 64'hDEE, 1, 0, 0, 64'hA03, 0, 4, 0, 0);
        add(1, 0, 0, 0, 0, 1, 0, 0, 64'hA03, 0, 4, 0, 0);
        for (int j = 0; j < 4; j++)
            add(1, 0, 0, 0, 0, 1, 1, 1, 64'hC00 + j, 0, 3 - j, 0, 0);
        run_table("t4_flush");

        // Refused requests: read empty ch2, write full ch1.
        for (int i = 0; i < 16; i++)
            add(1, 0, 1, 1, 64'hE00 + i, 0, 0, 0, 64'hC03, 0, i + 1, 0, 0);
        add(1, 0, 1, 1, 64'hEFF, 1, 2, 0, 64'hC03, 0, 16, 0, 0);
        add(1, 0, 0, 0, 0, 1, 1, 1, 64'hE00, 0, 15, 0, 0);
        run_table("t5_refuse");

        // Disabled traffic, including a flush, must not change state.
        for (int i = 0; i < 4; i++)
            add(0, (i == 2) ? 4'b0010 : 4'b0000, 1, 0, 64'hF00 + i,
                1, 1, 0, 64'hE00, 0, 15, 0, 0);
        add(1, 0, 0, 0, 0, 1, 1, 1, 64'hE01, 0, 14, 0, 0);
        run_table("t6_disable");

`ifdef DMA_FIFO_ERR_EN
        check_err("err_sticky", 4'b0010, 4'b0101);
        add(1, 4'b0110, 1, 1, 64'h999, 1, 2, 0, 64'hE01, 0, 0, 0, 0);
        run_table("err_flush");
        check_err("err_cleared", 4'b0000, 4'b0001);
`endif

        // Async reset in the middle of a write burst.
        @(negedge clk);
        enable = 1'b1; i_flush = 4'h0;
        i_wr_valid = 1'b1; i_wr_ch = 2'd2; i_wr_data = 64'h77;
        i_rd_valid = 1'b1; i_rd_ch = 2'd1;
        @(posedge clk);
        #2 nreset = 1'b0;
        #1 check("rst_mid", 0, 1'b0, 64'h0, 0, 0, 0, 0);
`ifdef DMA_FIFO_ERR_EN
        check_err("rst_mid_err", 4'h0, 4'h0);
`endif
        @(negedge clk);
        nreset = 1'b1;
        i_rd_valid = 1'b0;
        @(posedge clk);
        #1 check("rst_after", 0, 1'b0, 64'h0, 0, 0, 1, 0);
        add(1, 0, 0, 0, 0, 1, 2, 1, 64'h77, 0, 0, 0, 0);
        run_table("rst_read");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
